// File: rtl/multiport_ram_lvt_if.sv
// Access bundle for multiport_ram_lvt: packed read/write ports plus status outputs.
// Ports are packed per index, port k occupying [k*width +: width].
interface multiport_ram_lvt_if #(
  parameter int P_MEM_DEPTH = 16,
  parameter int P_MEM_WIDTH = 32,
  parameter int P_NUM_RD    = 4,
  parameter int P_NUM_WR    = 2
);
  localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH);

  logic [P_NUM_RD*LP_INDEX_WIDTH-1:0] rd_addr_i;
  logic [P_NUM_RD*P_MEM_WIDTH-1:0]    rd_data_o;
  logic [P_NUM_WR*LP_INDEX_WIDTH-1:0] wr_addr_i;
  logic [P_NUM_WR*P_MEM_WIDTH-1:0]    wr_data_i;
  logic [P_NUM_WR-1:0]                wr_valid_i;
  logic                               ready_o;
  logic                               wr_conflict_o;

  modport master (
    output rd_addr_i, wr_addr_i, wr_data_i, wr_valid_i,
    input  rd_data_o, ready_o, wr_conflict_o
  );

  modport slave (
    input  rd_addr_i, wr_addr_i, wr_data_i, wr_valid_i,
    output rd_data_o, ready_o, wr_conflict_o
  );
endinterface

// File: rtl/multiport_ram_lvt.sv
// N-read/M-write register file: one bank per write port, each replicated per read port,
// with a live-value table selecting the bank that last wrote each entry.
module multiport_ram_lvt #(
  parameter int P_MEM_DEPTH = 16,
  parameter int P_MEM_WIDTH = 32,
  parameter int P_NUM_RD    = 4,
  parameter int P_NUM_WR    = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  multiport_ram_lvt_if.slave bus
);
  localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH);
  localparam int LP_LVT_WIDTH   = (P_NUM_WR > 1) ? $clog2(P_NUM_WR) : 1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e                            state_q, state_d;
  logic [LP_INDEX_WIDTH-1:0]         clrCnt_q, clrCnt_d;
  logic [P_NUM_RD*P_MEM_WIDTH-1:0]   rdData_q, rdData_d;
  logic                              wrConflict_q, wrConflict_d;
  logic [LP_INDEX_WIDTH-1:0]         rdIdx;
  logic                              writeEn;

  logic [P_MEM_WIDTH-1:0]  bank_q [P_NUM_WR][P_NUM_RD][P_MEM_DEPTH];
  logic [LP_LVT_WIDTH-1:0] lvt_q  [P_MEM_DEPTH];

  assign writeEn = (state_q == ST_RUN) && !rst_i;

  // Clear sweep walks every entry once, then the RAM stays in RUN until the next reset.
  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    if (state_q == ST_CLEAR) begin
      clrCnt_d = clrCnt_q + 1'b1;
      if (clrCnt_q == LP_INDEX_WIDTH'(P_MEM_DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  // Read path is write-first: a same-cycle write to the read address bypasses the banks,
  // and the highest-index valid writer wins, matching the LVT update order below.
  always_comb begin
    rdData_d     = '0;
    wrConflict_d = 1'b0;
    rdIdx        = '0;
    if (state_q == ST_RUN) begin
      for (int k = 0; k < P_NUM_RD; k++) begin
        rdIdx = bus.rd_addr_i[k*LP_INDEX_WIDTH +: LP_INDEX_WIDTH];
        rdData_d[k*P_MEM_WIDTH +: P_MEM_WIDTH] = bank_q[lvt_q[rdIdx]][k][rdIdx];
        for (int j = 0; j < P_NUM_WR; j++) begin
          if (bus.wr_valid_i[j] &&
              bus.wr_addr_i[j*LP_INDEX_WIDTH +: LP_INDEX_WIDTH] == rdIdx) begin
            rdData_d[k*P_MEM_WIDTH +: P_MEM_WIDTH] = bus.wr_data_i[j*P_MEM_WIDTH +: P_MEM_WIDTH];
          end
        end
      end
      for (int i = 0; i < P_NUM_WR; i++) begin
        for (int j = i + 1; j < P_NUM_WR; j++) begin
          if (bus.wr_valid_i[i] && bus.wr_valid_i[j] &&
              bus.wr_addr_i[i*LP_INDEX_WIDTH +: LP_INDEX_WIDTH] ==
              bus.wr_addr_i[j*LP_INDEX_WIDTH +: LP_INDEX_WIDTH]) begin
            wrConflict_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_CLEAR;
      clrCnt_q     <= '0;
      rdData_q     <= '0;
      wrConflict_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clrCnt_q     <= clrCnt_d;
      rdData_q     <= rdData_d;
      wrConflict_q <= wrConflict_d;
    end
  end

  // Storage has no reset; the sweep zeroes it, and later writes go to the writer's own bank.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == ST_CLEAR) begin
      for (int j = 0; j < P_NUM_WR; j++) begin
        for (int k = 0; k < P_NUM_RD; k++) begin
          bank_q[j][k][clrCnt_q] <= '0;
        end
      end
      lvt_q[clrCnt_q] <= '0;
    end else if (writeEn) begin
      for (int j = 0; j < P_NUM_WR; j++) begin
        if (bus.wr_valid_i[j]) begin
          for (int k = 0; k < P_NUM_RD; k++) begin
            bank_q[j][k][bus.wr_addr_i[j*LP_INDEX_WIDTH +: LP_INDEX_WIDTH]] <=
              bus.wr_data_i[j*P_MEM_WIDTH +: P_MEM_WIDTH];
          end
          lvt_q[bus.wr_addr_i[j*LP_INDEX_WIDTH +: LP_INDEX_WIDTH]] <= LP_LVT_WIDTH'(j);
        end
      end
    end
  end

  assign bus.rd_data_o     = rdData_q;
  assign bus.ready_o       = (state_q == ST_RUN);
  assign bus.wr_conflict_o = wrConflict_q;
endmodule

// File: tb/tb_multiport_ram_lvt.sv
// Self-checking bench for multiport_ram_lvt: directed scenarios plus random traffic
// compared against a flat array model of the RAM contents.
module tb_multiport_ram_lvt;
  localparam int D   = 16;
  localparam int W   = 32;
  localparam int NR  = 4;
  localparam int NW  = 2;
  localparam int IDX = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [W-1:0]   model [D];
  logic [IDX-1:0] rdA   [NR];
  logic [IDX-1:0] wrA   [NW];
  logic [W-1:0]   wrD   [NW];
  logic           wrV   [NW];
  logic [W-1:0]   expRd [NR];
  logic           expConf;

  multiport_ram_lvt_if #(.P_MEM_DEPTH(D), .P_MEM_WIDTH(W), .P_NUM_RD(NR), .P_NUM_WR(NW)) bus ();

  multiport_ram_lvt #(.P_MEM_DEPTH(D), .P_MEM_WIDTH(W), .P_NUM_RD(NR), .P_NUM_WR(NW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setIdle();
    for (int j = 0; j < NW; j++) begin
      wrV[j] = 1'b0;
      wrA[j] = '0;
      wrD[j] = '0;
    end
    for (int k = 0; k < NR; k++) rdA[k] = '0;
  endtask

  task automatic clearModel();
    for (int a = 0; a < D; a++) model[a] = '0;
  endtask

  task automatic driveRandomRaw();
    bus.rd_addr_i  = $urandom;
    bus.wr_addr_i  = {$urandom, $urandom};
    bus.wr_data_i  = {$urandom, $urandom};
    bus.wr_valid_i = NW'($urandom);
  endtask

  // Drives one RUN cycle, advances the model (ascending port order, so the higher port wins)
  // and leaves the outputs expected one edge later in expRd/expConf.
  task automatic applyStimulus();
    for (int k = 0; k < NR; k++) bus.rd_addr_i[k*IDX +: IDX] = rdA[k];
    for (int j = 0; j < NW; j++) begin
      bus.wr_addr_i[j*IDX +: IDX] = wrA[j];
      bus.wr_data_i[j*W +: W]     = wrV[j] ? wrD[j] : 'x;
      bus.wr_valid_i[j]           = wrV[j];
    end
    expConf = 1'b0;
    for (int i = 0; i < NW; i++)
      for (int j = i + 1; j < NW; j++)
        if (wrV[i] && wrV[j] && wrA[i] == wrA[j]) expConf = 1'b1;
    for (int j = 0; j < NW; j++)
      if (wrV[j]) model[wrA[j]] = wrD[j];
    for (int k = 0; k < NR; k++) expRd[k] = model[rdA[k]];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int zeros;
    rst = 1'b1;
    driveRandomRaw();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.rd_data_o !== '0 || bus.wr_conflict_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: ready=%b conf=%b rd=%h, required ready=0 conf=0 rd=0",
               bus.ready_o, bus.wr_conflict_o, bus.rd_data_o);
    end
    zeros = 0;
    while (bus.ready_o !== 1'b1 && zeros < 40) begin
      zeros++;
      checks++;
      if (bus.rd_data_o !== '0 || bus.wr_conflict_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL clear_outputs: rd=%h conf=%b, required 0/0", bus.rd_data_o, bus.wr_conflict_o);
      end
      driveRandomRaw();
      @(posedge clk); #1;
    end
    checks++;
    if (zeros != D) begin
      errors++;
      $display("[TB] FAIL sweep_length: ready low for %0d cycles, required %0d", zeros, D);
    end
    clearModel();
    setIdle();
    for (int r = 0; r < D / NR; r++) begin
      for (int k = 0; k < NR; k++) rdA[k] = IDX'(r * NR + k);
      applyStimulus();
      for (int k = 0; k < NR; k++) begin
        checks++;
        if (bus.rd_data_o[k*W +: W] !== 32'h0) begin
          errors++;
          $display("[TB] FAIL cleared_read port%0d addr%0d: got %h, required 0",
                   k, r * NR + k, bus.rd_data_o[k*W +: W]);
        end
      end
    end
  endtask

  task automatic test_latency();
    setIdle();
    wrV[0] = 1'b1; wrA[0] = 4'd3; wrD[0] = 32'hDEADBEEF;
    rdA[2] = 4'd0;
    applyStimulus();
    setIdle();
    rdA[2] = 4'd3;
    applyStimulus();
    checks++;
    if (bus.rd_data_o[2*W +: W] !== 32'hDEADBEEF || expRd[2] !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL latency port2: got %h, required DEADBEEF", bus.rd_data_o[2*W +: W]);
    end
  endtask

  task automatic test_forwarding();
    setIdle();
    wrV[1] = 1'b1; wrA[1] = 4'd5; wrD[1] = 32'h12345678;
    for (int k = 0; k < NR; k++) rdA[k] = 4'd5;
    applyStimulus();
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (bus.rd_data_o[k*W +: W] !== 32'h12345678) begin
        errors++;
        $display("[TB] FAIL forward port%0d: got %h, required 12345678", k, bus.rd_data_o[k*W +: W]);
      end
    end
  endtask

  task automatic test_conflict();
    setIdle();
    wrV[0] = 1'b1; wrA[0] = 4'd7; wrD[0] = 32'hAAAA0000;
    wrV[1] = 1'b1; wrA[1] = 4'd7; wrD[1] = 32'h5555FFFF;
    rdA[0] = 4'd7;
    applyStimulus();
    checks++;
    if (bus.wr_conflict_o !== 1'b1 || bus.rd_data_o[0 +: W] !== 32'h5555FFFF) begin
      errors++;
      $display("[TB] FAIL conflict_cycle: conf=%b rd=%h, required 1 5555FFFF",
               bus.wr_conflict_o, bus.rd_data_o[0 +: W]);
    end
    setIdle();
    rdA[3] = 4'd7;
    applyStimulus();
    checks++;
    if (bus.wr_conflict_o !== 1'b0 || bus.rd_data_o[3*W +: W] !== 32'h5555FFFF) begin
      errors++;
      $display("[TB] FAIL conflict_after: conf=%b rd=%h, required 0 5555FFFF",
               bus.wr_conflict_o, bus.rd_data_o[3*W +: W]);
    end
  endtask

  task automatic test_lvt();
    logic [W-1:0] seqData [3];
    int           seqPort [3];
    seqData = '{32'h1, 32'h2, 32'h3};
    seqPort = '{0, 1, 0};
    for (int s = 0; s < 3; s++) begin
      setIdle();
      wrV[seqPort[s]] = 1'b1;
      wrA[seqPort[s]] = 4'd9;
      wrD[seqPort[s]] = seqData[s];
      applyStimulus();
    end
    setIdle();
    rdA[0] = 4'd9;
    rdA[1] = 4'd10;
    applyStimulus();
    checks++;
    if (bus.rd_data_o[0 +: W] !== 32'h3 || bus.rd_data_o[W +: W] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL lvt: addr9=%h addr10=%h, required 3 and 0",
               bus.rd_data_o[0 +: W], bus.rd_data_o[W +: W]);
    end
  endtask

  task automatic test_reset_mid();
    int zeros;
    setIdle();
    wrV[0] = 1'b1; wrA[0] = 4'd1; wrD[0] = 32'hFF;
    applyStimulus();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_drop: got %b, required 0", bus.ready_o);
    end
    for (int c = 0; c < 5; c++) begin
      driveRandomRaw();
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    zeros = 0;
    while (bus.ready_o !== 1'b1 && zeros < 40) begin
      zeros++;
      driveRandomRaw();
      @(posedge clk); #1;
    end
    checks++;
    if (zeros != D) begin
      errors++;
      $display("[TB] FAIL resweep_length: ready low for %0d cycles, required %0d", zeros, D);
    end
    clearModel();
    setIdle();
    rdA[1] = 4'd1;
    applyStimulus();
    checks++;
    if (bus.rd_data_o[W +: W] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_clears_addr1: got %h, required 0", bus.rd_data_o[W +: W]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      for (int j = 0; j < NW; j++) begin
        wrV[j] = ($urandom_range(0, 2) != 0);
        wrA[j] = IDX'($urandom);
        wrD[j] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) wrA[1] = wrA[0];
      for (int k = 0; k < NR; k++)
        rdA[k] = ($urandom_range(0, 2) == 0) ? wrA[$urandom_range(0, NW - 1)] : IDX'($urandom);
      applyStimulus();
      for (int k = 0; k < NR; k++) begin
        checks++;
        if (bus.rd_data_o[k*W +: W] !== expRd[k]) begin
          errors++;
          $display("[TB] FAIL random_read cycle%0d port%0d: got %h, required %h",
                   c, k, bus.rd_data_o[k*W +: W], expRd[k]);
        end
      end
      checks++;
      if (bus.wr_conflict_o !== expConf || bus.ready_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL random_status cycle%0d: conf=%b ready=%b, required conf=%b ready=1",
                 c, bus.wr_conflict_o, bus.ready_o, expConf);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.rd_addr_i  = '0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.wr_valid_i = '0;
    setIdle();
    clearModel();
    test_reset();
    test_latency();
    test_forwarding();
    test_conflict();
    test_lvt();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
